fp_sum_result_collector: RTL and testbench

FP_SUM_RESULT_COLLECTOR -- requirements
Module: fp_sum_result_collector

---
 rtl/fp_sum_result_collector.sv | 139 +++++++++++++
 tb/tb_fp_sum_result_collector.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sum_result_collector.sv
`default_nettype none
// =============================================================================
// Module   : fp_sum_result_collector
// Purpose  : Credit-gated issue to a fixed-latency FP summator plus an in-order
//            result FIFO. Optional macro: FP_COLLECT_STICKY_STATUS_EN.
// Revision : 1.0
// =============================================================================
module fp_sum_result_collector #(
   parameter int LATENCY = 4,
   parameter int DEPTH   = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_vld_i,
   output logic                       in_rdy_o,
   output logic                       sum_vld_o,
   input  logic [31:0]                answer_i,
   input  logic [1:0]                 num_status_i,
   output logic                       out_vld_o,
   input  logic                       out_rdy_i,
   output logic [31:0]                out_data_o,
   output logic [1:0]                 out_status_o,
`ifdef FP_COLLECT_STICKY_STATUS_EN
   input  logic                       sticky_clr_i,
   output logic [1:0]                 sticky_status_o,
`endif
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int OUT_W = $clog2(LATENCY + DEPTH + 1);

   logic [LATENCY-1:0] vld_sr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [33:0]        mem [DEPTH];
   logic [33:0]        head;
   logic [OUT_W-1:0]   inflight;
   logic [OUT_W-1:0]   outstanding;
   logic               credit_ok;
   logic               issue;
   logic               pop;
   logic               capture;

   // Every issued op already owns a FIFO slot, so capture can never overflow.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) begin
         inflight = inflight + OUT_W'(vld_sr[i]);
      end
      outstanding = inflight + OUT_W'(count);
      credit_ok   = (outstanding < OUT_W'(DEPTH));
   end

   assign in_rdy_o  = rst_i & credit_ok;
   assign issue     = in_vld_i & in_rdy_o;
   assign sum_vld_o = issue;
   assign capture   = vld_sr[LATENCY-1];
   assign out_vld_o = (count != '0);
   assign pop       = out_vld_o & out_rdy_i;

   generate
      if (LATENCY == 1) begin : g_sr_single
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               vld_sr <= '0;
            end else begin
               vld_sr <= issue;
            end
         end
      end else begin : g_sr_multi
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               vld_sr <= '0;
            end else begin
               vld_sr <= {vld_sr[LATENCY-2:0], issue};
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (capture) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({capture, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is never read while empty, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         mem[wr_ptr] <= {num_status_i, answer_i};
      end
   end

   assign head         = mem[rd_ptr];
   assign out_data_o   = out_vld_o ? head[31:0]  : 32'h0;
   assign out_status_o = out_vld_o ? head[33:32] : 2'b00;
   assign count_o      = count;

`ifdef FP_COLLECT_STICKY_STATUS_EN
   logic [1:0] sticky;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sticky <= 2'b00;
      end else if (sticky_clr_i) begin
         sticky <= 2'b00;
      end else if (pop) begin
         sticky <= sticky | out_status_o;
      end
   end

   assign sticky_status_o = sticky;
`endif

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(capture && (count == CNT_W'(DEPTH))));

   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_i)
      !(pop && (count == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fp_sum_result_collector.sv
`default_nettype none
// =============================================================================
// Module   : tb_fp_sum_result_collector
// Purpose  : Scoreboard bench for fp_sum_result_collector with a summator model.
// Revision : 1.0
// =============================================================================
module tb_fp_sum_result_collector;

   // DEPTH >= LAT+2 so registered credit accounting never throttles a full-rate stream.
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             in_vld_i;
   logic             in_rdy_o;
   logic             sum_vld_o;
   logic [31:0]      answer_i;
   logic [1:0]       num_status_i;
   logic             out_vld_o;
   logic             out_rdy_i;
   logic [31:0]      out_data_o;
   logic [1:0]       out_status_o;
   logic [CNT_W-1:0] count_o;
`ifdef FP_COLLECT_STICKY_STATUS_EN
   logic             sticky_clr_i;
   logic [1:0]       sticky_status_o;
`endif

   int          vectors     = 0;
   int          miscompares = 0;
   logic [33:0] exp_q [$];
   logic [33:0] cur_word;
   logic [33:0] got;
   logic [33:0] exp_word;
   logic [33:0] force_word;
   bit          use_force;
   bit          issued;
   bit          popped;

   fp_sum_result_collector #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .in_vld_i        (in_vld_i),
      .in_rdy_o        (in_rdy_o),
      .sum_vld_o       (sum_vld_o),
      .answer_i        (answer_i),
      .num_status_i    (num_status_i),
      .out_vld_o       (out_vld_o),
      .out_rdy_i       (out_rdy_i),
      .out_data_o      (out_data_o),
      .out_status_o    (out_status_o),
`ifdef FP_COLLECT_STICKY_STATUS_EN
      .sticky_clr_i    (sticky_clr_i),
      .sticky_status_o (sticky_status_o),
`endif
      .count_o         (count_o)
   );

   always #5 clk_i = ~clk_i;

   // Summator model: the word chosen at issue appears on answer_i LAT cycles later.
   logic        pv [LAT];
   logic [33:0] pw [LAT];
   logic [33:0] junk;

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
      end else begin
         pv[0] <= sum_vld_o;
         pw[0] <= cur_word;
         for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pw[i] <= pw[i-1];
         end
      end
   end

   always @(posedge clk_i) junk <= {2'($urandom), 32'($urandom)};

   assign {num_status_i, answer_i} = pv[LAT-1] ? pw[LAT-1] : junk;

   // One cycle: drive at negedge, observe 1ns later; records issue and pop.
   task automatic step(input logic vld, input logic rdy);
      @(negedge clk_i);
      in_vld_i  = vld;
      out_rdy_i = rdy;
      cur_word  = use_force ? force_word : {2'($urandom_range(3)), 32'($urandom)};
      #1;
      issued = sum_vld_o;
      if (issued) exp_q.push_back(cur_word);
      popped   = out_vld_o & out_rdy_i;
      got      = {out_status_o, out_data_o};
      exp_word = 'x;
      if (popped && exp_q.size() > 0) exp_word = exp_q.pop_front();
   endtask

   task automatic test_reset();
      rst_i     = 1'b0;
      in_vld_i  = 1'b1;
      out_rdy_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      vectors++;
      if (sum_vld_o !== 1'b0) begin
         miscompares++; $display("FAIL reset_sum_vld: got %b want 0", sum_vld_o);
      end
      vectors++;
      if (out_vld_o !== 1'b0) begin
         miscompares++; $display("FAIL reset_out_vld: got %b want 0", out_vld_o);
      end
      vectors++;
      if (count_o !== '0) begin
         miscompares++; $display("FAIL reset_count: got %0d want 0", count_o);
      end
      vectors++;
      if ({out_status_o, out_data_o} !== 34'h0) begin
         miscompares++; $display("FAIL reset_out_data: got %h want 0", {out_status_o, out_data_o});
      end
      in_vld_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      vectors++;
      if (in_rdy_o !== 1'b1) begin
         miscompares++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy_o);
      end
      exp_q.delete();
   endtask

   task automatic test_single();
      int  lat;
      bit  found;
      lat = 0; found = 0;
      use_force  = 1;
      force_word = {2'b00, 32'h40400000};
      step(1, 1);
      use_force = 0;
      vectors++;
      if (!issued) begin
         miscompares++; $display("FAIL single_issue: got 0 want 1");
      end
      for (int i = 1; i <= 20 && !found; i++) begin
         step(0, 1);
         if (out_vld_o) begin
            found = 1; lat = i;
            vectors++;
            if (count_o !== CNT_W'(1)) begin
               miscompares++; $display("FAIL single_count: got %0d want 1", count_o);
            end
            vectors++;
            if (got !== exp_word) begin
               miscompares++; $display("FAIL single_data: got %h want %h", got, exp_word);
            end
         end
      end
      vectors++;
      if (lat != LAT + 1) begin
         miscompares++; $display("FAIL single_latency: got %0d want %0d", lat, LAT + 1);
      end
      step(0, 1);
      vectors++;
      if (out_vld_o !== 1'b0 || count_o !== '0) begin
         miscompares++; $display("FAIL single_empty: got vld %b cnt %0d want 0 0", out_vld_o, count_o);
      end
   endtask

   task automatic test_stall();
      int          issues;
      bit          moved;
      logic [33:0] hold;
      issues = 0; moved = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 0);
         if (issued) issues++;
      end
      vectors++;
      if (issues != DEPTH) begin
         miscompares++; $display("FAIL stall_issues: got %0d want %0d", issues, DEPTH);
      end
      vectors++;
      if (in_rdy_o !== 1'b0) begin
         miscompares++; $display("FAIL stall_in_rdy: got %b want 0", in_rdy_o);
      end
      vectors++;
      if (count_o !== CNT_W'(DEPTH)) begin
         miscompares++; $display("FAIL stall_count: got %0d want %0d", count_o, DEPTH);
      end
      hold = got;
      for (int i = 0; i < 3; i++) begin
         step(1, 0);
         if (got !== hold || issued) moved = 1;
      end
      vectors++;
      if (moved) begin
         miscompares++; $display("FAIL stall_hold: got %h want %h", got, hold);
      end
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         step(0, 1);
         if (popped) begin
            vectors++;
            if (got !== exp_word) begin
               miscompares++; $display("FAIL stall_drain: got %h want %h", got, exp_word);
            end
         end
      end
      step(0, 0);
      vectors++;
      if (exp_q.size() != 0 || count_o !== '0) begin
         miscompares++; $display("FAIL stall_empty: got %0d left cnt %0d want 0 0", exp_q.size(), count_o);
      end
   endtask

   task automatic test_streaming();
      int issues, pops;
      bit rdy_low;
      issues = 0; pops = 0; rdy_low = 0;
      for (int i = 0; i < 16; i++) begin
         step(1, 1);
         if (!in_rdy_o) rdy_low = 1;
         if (issued) issues++;
         if (popped) begin
            pops++;
            vectors++;
            if (got !== exp_word) begin
               miscompares++; $display("FAIL stream_data: got %h want %h", got, exp_word);
            end
         end
      end
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         step(0, 1);
         if (popped) begin
            pops++;
            vectors++;
            if (got !== exp_word) begin
               miscompares++; $display("FAIL stream_data: got %h want %h", got, exp_word);
            end
         end
      end
      vectors++;
      if (rdy_low) begin
         miscompares++; $display("FAIL stream_in_rdy: got 0 want 1");
      end
      vectors++;
      if (issues != 16 || pops != 16) begin
         miscompares++; $display("FAIL stream_counts: got %0d/%0d want 16/16", issues, pops);
      end
   endtask

   task automatic test_cap_pop();
      for (int i = 0; i < 3; i++) step(1, 0);
      for (int i = 3; i <= LAT + 1; i++) step(0, 0);
      step(0, 1);
      vectors++;
      if (count_o !== CNT_W'(2)) begin
         miscompares++; $display("FAIL cappop_pre_count: got %0d want 2", count_o);
      end
      vectors++;
      if (got !== exp_word) begin
         miscompares++; $display("FAIL cappop_pop: got %h want %h", got, exp_word);
      end
      step(0, 0);
      vectors++;
      if (count_o !== CNT_W'(2)) begin
         miscompares++; $display("FAIL cappop_count: got %0d want 2", count_o);
      end
      vectors++;
      if (exp_q.size() == 0 || got !== exp_q[0]) begin
         miscompares++; $display("FAIL cappop_head: got %h want %h", got, exp_q.size() ? exp_q[0] : 'x);
      end
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         step(0, 1);
         if (popped) begin
            vectors++;
            if (got !== exp_word) begin
               miscompares++; $display("FAIL cappop_drain: got %h want %h", got, exp_word);
            end
         end
      end
      step(0, 0);
   endtask

   task automatic test_reset_mid();
      bit stale;
      bit found;
      stale = 0; found = 0;
      for (int i = 0; i < 4; i++) step(1, 0);
      step(0, 0);
      vectors++;
      if (count_o !== CNT_W'(2)) begin
         miscompares++; $display("FAIL rstmid_pre_count: got %0d want 2", count_o);
      end
      rst_i = 1'b0;
      #1;
      vectors++;
      if (out_vld_o !== 1'b0 || count_o !== '0 || {out_status_o, out_data_o} !== 34'h0) begin
         miscompares++;
         $display("FAIL rstmid_clear: got vld %b cnt %0d data %h want 0 0 0", out_vld_o, count_o, {out_status_o, out_data_o});
      end
      exp_q.delete();
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(0, 1);
         if (out_vld_o) stale = 1;
      end
      vectors++;
      if (stale || in_rdy_o !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_stale: got stale %b rdy %b want 0 1", stale, in_rdy_o);
      end
      step(1, 1);
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, 1);
         if (popped) begin
            found = 1;
            vectors++;
            if (got !== exp_word) begin
               miscompares++; $display("FAIL rstmid_fresh: got %h want %h", got, exp_word);
            end
         end
      end
      if (!found) begin
         vectors++; miscompares++; $display("FAIL rstmid_fresh: got timeout want result");
      end
      step(0, 0);
   endtask

`ifdef FP_COLLECT_STICKY_STATUS_EN
   task automatic test_sticky();
      sticky_clr_i = 1'b1;
      @(posedge clk_i); #1;
      sticky_clr_i = 1'b0;
      use_force  = 1;
      force_word = {2'b01, 32'h3f800000};
      step(1, 0);
      force_word = {2'b10, 32'h7f800000};
      step(1, 0);
      use_force = 0;
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         step(0, 1);
         if (popped) begin
            vectors++;
            if (got !== exp_word) begin
               miscompares++; $display("FAIL sticky_data: got %h want %h", got, exp_word);
            end
         end
      end
      step(0, 0);
      vectors++;
      if (sticky_status_o !== 2'b11) begin
         miscompares++; $display("FAIL sticky_or: got %b want 11", sticky_status_o);
      end
      sticky_clr_i = 1'b1;
      @(posedge clk_i); #1;
      sticky_clr_i = 1'b0;
      step(0, 0);
      vectors++;
      if (sticky_status_o !== 2'b00) begin
         miscompares++; $display("FAIL sticky_clr: got %b want 00", sticky_status_o);
      end
      use_force  = 1;
      force_word = {2'b01, 32'h00000001};
      step(1, 0);
      use_force = 0;
      for (int i = 0; i < 20 && !out_vld_o; i++) step(0, 0);
      step(0, 1);
      sticky_clr_i = 1'b1;
      @(posedge clk_i); #1;
      sticky_clr_i = 1'b0;
      step(0, 0);
      vectors++;
      if (sticky_status_o !== 2'b00 || exp_q.size() != 0) begin
         miscompares++; $display("FAIL sticky_clr_wins: got %b left %0d want 00 0", sticky_status_o, exp_q.size());
      end
   endtask
`endif

   initial begin
      rst_i     = 1'b0;
      in_vld_i  = 1'b0;
      out_rdy_i = 1'b0;
      cur_word  = '0;
      use_force = 0;
`ifdef FP_COLLECT_STICKY_STATUS_EN
      sticky_clr_i = 1'b0;
`endif
      test_reset();
      test_single();
      test_stall();
      test_streaming();
      test_cap_pop();
      test_reset_mid();
`ifdef FP_COLLECT_STICKY_STATUS_EN
      test_sticky();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
